// File: rtl/scan_display_ctrl_pkg.sv
// lab2_pkg: shared widths, scan FSM state type and the 7-segment digit table
// for scan_display_ctrl and its seg7 decoder.
package lab2_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}, indexed by hex digit 0..F.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/scan_display_ctrl_seg7.sv
// seg7: hex digit to active-low 7-segment decoder.
// Ports: digit (4-bit value in), seg (7-bit active-low segment drive out).
module seg7
  import lab2_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl: steps a scan address through a 32x4 RAM on each tick,
// reads the addressed word and latches address/data for a 7-segment display.
// User writes go straight to the RAM port every cycle they are requested.
// Ports:
//   CLOCK_50            system clock, rising edge
//   Reset               asynchronous, active-high
//   tick                one-cycle advance pulse
//   wr_req/wr_addr/wr_data   user write request
//   ram_addr/ram_wren/ram_wdata  RAM port, ram_q read data (RD_LAT cycles)
//   disp_addr/disp_data last scanned address and its data
//   HEX0/HEX2/HEX3      active-low digits: data, addr[3:0], addr[4]
module scan_display_ctrl
  import lab2_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              tick,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   scan_addr, scan_addr_n;
  logic                wcnt, wcnt_n;
  logic                pending, pending_n;
  logic                refresh, refresh_n;
  logic [ADDR_W-1:0]   disp_addr_n;
  logic [DATA_W-1:0]   disp_data_n;
  logic                wr_hit;
  logic                rd_last;

  // A write to the displayed location makes the shown value stale.
  assign wr_hit  = wr_req && (wr_addr == disp_addr);
  assign rd_last = (wcnt == 1'(RD_LAT - 1));

  // Writes own the RAM port whenever requested; otherwise the scan address
  // is presented so the ISSUE cycle's edge registers the read.
  assign ram_wren  = wr_req;
  assign ram_addr  = wr_req ? wr_addr : scan_addr;
  assign ram_wdata = wr_data;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      scan_addr <= '0;
      wcnt      <= 1'b0;
      pending   <= 1'b0;
      refresh   <= 1'b1;  // forces a read of address 0 after release
      disp_addr <= '0;
      disp_data <= '0;
    end else begin
      state     <= state_n;
      scan_addr <= scan_addr_n;
      wcnt      <= wcnt_n;
      pending   <= pending_n;
      refresh   <= refresh_n;
      disp_addr <= disp_addr_n;
      disp_data <= disp_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    scan_addr_n = scan_addr;
    wcnt_n      = wcnt;
    pending_n   = pending;
    refresh_n   = refresh;
    disp_addr_n = disp_addr;
    disp_data_n = disp_data;

    // One-deep tick memory while a read is in flight; extra ticks drop.
    if (tick && state != S_IDLE) pending_n = 1'b1;
    if (wr_hit) refresh_n = 1'b1;

    case (state)
      S_IDLE: begin
        // Tick and pending merge into a single increment; entering ISSUE
        // always satisfies any refresh request.
        if (tick || pending) begin
          scan_addr_n = scan_addr + 5'd1;
          pending_n   = 1'b0;
          refresh_n   = 1'b0;
          state_n     = S_ISSUE;
        end else if (refresh) begin
          refresh_n = 1'b0;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A write steals the port, so the read is retried next cycle.
        if (!wr_req) begin
          wcnt_n  = 1'b0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_last) begin
          disp_data_n = ram_q;
          disp_addr_n = scan_addr;
          wcnt_n      = 1'b0;
          state_n     = S_IDLE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  seg7 u_hex0 (.digit(disp_data),                  .seg(HEX0));
  seg7 u_hex2 (.digit(disp_addr[3:0]),             .seg(HEX2));
  seg7 u_hex3 (.digit({3'b000, disp_addr[4]}),     .seg(HEX3));

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: RD_LAT=1 and RD_LAT=2 instances share one
// stimulus stream, each with its own RAM. A transaction-level model
// (snapshot of memory at the read issue, completion due RD_LAT edges later)
// predicts the outputs, compared every cycle; directed scenarios add literal
// expectations.
module tb_scan_display_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       Reset    = 1'b1;
  logic       tick     = 1'b0;
  logic       wr_req   = 1'b0;
  logic [4:0] wr_addr  = '0;
  logic [3:0] wr_data  = '0;

  logic [4:0] ram_addr  [2];
  logic       ram_wren  [2];
  logic [3:0] ram_wdata [2];
  logic [3:0] ram_q     [2];
  logic [4:0] disp_addr [2];
  logic [3:0] disp_data [2];
  logic [6:0] hex0 [2];
  logic [6:0] hex2 [2];
  logic [6:0] hex3 [2];

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  scan_display_ctrl #(.RD_LAT(1)) u_lat1 (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .tick(tick), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr[0]),
    .ram_wren(ram_wren[0]), .ram_wdata(ram_wdata[0]), .ram_q(ram_q[0]),
    .disp_addr(disp_addr[0]), .disp_data(disp_data[0]),
    .HEX0(hex0[0]), .HEX2(hex2[0]), .HEX3(hex3[0]));

  scan_display_ctrl #(.RD_LAT(2)) u_lat2 (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .tick(tick), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr[1]),
    .ram_wren(ram_wren[1]), .ram_wdata(ram_wdata[1]), .ram_q(ram_q[1]),
    .disp_addr(disp_addr[1]), .disp_data(disp_data[1]),
    .HEX0(hex0[1]), .HEX2(hex2[1]), .HEX3(hex3[1]));

  function automatic logic [3:0] init_val(int i);
    if (i == 0) return 4'h7;
    if (i == 1) return 4'hA;
    return 4'((i * 7 + 3) % 16);
  endfunction

  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lat%0d at %0t: got %0h expected %0h", nm, k + 1,
               $time, act, exp);
    end
  endtask

  // RAMs: read-before-write; address registered on the edge, RD_LAT=2 adds
  // an output register.
  logic [3:0] ram [2][32];
  logic [3:0] s1 [2];
  logic [3:0] q2;
  assign ram_q[0] = s1[0];
  assign ram_q[1] = q2;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) ram[k][i] = init_val(i);
    forever begin
      @(posedge CLOCK_50);
      for (int k = 0; k < 2; k++) begin
        if (ram_wren[k]) ram[k][ram_addr[k]] <= ram_wdata[k];
        s1[k] <= ram[k][ram_addr[k]];
      end
      q2 <= s1[1];
    end
  end

  // Behavioural model. m_st: 0 idle, 1 read waiting for a free port,
  // 2 read in flight (completes at edge m_due with data m_snap).
  int         m_st   [2];
  logic [4:0] m_scan [2];
  logic [4:0] m_da   [2];
  logic [3:0] m_dd   [2];
  logic [3:0] m_snap [2];
  bit         m_pend [2];
  bit         m_ref  [2];
  int         m_due  [2];
  logic [3:0] m_mem  [32];
  int         ecnt = 0;

  initial begin
    bit hit;
    for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_scan[k] = 0; m_pend[k] = 0; m_ref[k] = 1;
      m_da[k] = 0; m_dd[k] = 0; m_due[k] = 0; m_snap[k] = 0;
    end
    forever begin
      @(posedge CLOCK_50 or posedge Reset);
      if (Reset) begin
        for (int k = 0; k < 2; k++) begin
          m_st[k] = 0; m_scan[k] = 0; m_pend[k] = 0; m_ref[k] = 1;
          m_da[k] = 0; m_dd[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          hit = wr_req && (wr_addr == m_da[k]);
          case (m_st[k])
            0: begin
              if (tick || m_pend[k]) begin
                m_scan[k] = m_scan[k] + 5'd1;
                m_pend[k] = 0; m_ref[k] = 0; m_st[k] = 1;
              end else if (m_ref[k]) begin
                m_ref[k] = 0; m_st[k] = 1;
              end else if (hit) m_ref[k] = 1;
            end
            1: begin
              if (tick) m_pend[k] = 1;
              if (hit) m_ref[k] = 1;
              if (!wr_req) begin
                m_snap[k] = m_mem[m_scan[k]];
                m_due[k]  = ecnt + k + 1;
                m_st[k]   = 2;
              end
            end
            default: begin
              if (tick) m_pend[k] = 1;
              if (hit) m_ref[k] = 1;
              if (ecnt == m_due[k]) begin
                m_da[k] = m_scan[k]; m_dd[k] = m_snap[k]; m_st[k] = 0;
              end
            end
          endcase
        end
        if (wr_req) m_mem[wr_addr] = wr_data;
        ecnt++;
      end
    end
  end

  // Per-cycle comparison against the model, mid low phase.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("ram_wren", k, 32'(ram_wren[k]), 32'(wr_req));
        chk("ram_addr", k, 32'(ram_addr[k]), 32'(wr_req ? wr_addr : m_scan[k]));
        if (wr_req) chk("ram_wdata", k, 32'(ram_wdata[k]), 32'(wr_data));
        chk("disp_addr", k, 32'(disp_addr[k]), 32'(m_da[k]));
        chk("disp_data", k, 32'(disp_data[k]), 32'(m_dd[k]));
        chk("HEX0", k, 32'(hex0[k]), 32'(seg_of(m_dd[k])));
        chk("HEX2", k, 32'(hex2[k]), 32'(seg_of(m_da[k][3:0])));
        chk("HEX3", k, 32'(hex3[k]), 32'(seg_of({3'b000, m_da[k][4]})));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      #2;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(9);
  endtask

  localparam logic [4:0] WA [3] = '{5'd20, 5'd6, 5'd21};
  localparam logic [3:0] WD [3] = '{4'h3, 4'h9, 4'h4};

  initial begin
    logic [4:0] ea;
    // Reset state, no clock edge yet.
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_disp_addr", k, 32'(disp_addr[k]), 32'd0);
      chk("rst_disp_data", k, 32'(disp_data[k]), 32'd0);
      chk("rst_ram_addr", k, 32'(ram_addr[k]), 32'd0);
      chk("rst_ram_wren", k, 32'(ram_wren[k]), 32'd0);
      chk("rst_HEX0", k, 32'(hex0[k]), 32'h40);
      chk("rst_HEX2", k, 32'(hex2[k]), 32'h40);
      chk("rst_HEX3", k, 32'(hex3[k]), 32'h40);
    end
    step(2);
    Reset = 1'b0;

    // Automatic refresh read of address 0.
    step(2);
    chk("refresh_early", 0, 32'(disp_data[0]), 32'h0);
    step(1);
    chk("refresh_data", 0, 32'(disp_data[0]), 32'h7);
    chk("refresh_HEX0", 0, 32'(hex0[0]), 32'b1111000);
    chk("refresh_data", 1, 32'(disp_data[1]), 32'h0);
    step(1);
    chk("refresh_data", 1, 32'(disp_data[1]), 32'h7);
    step(3);

    // Tick latency.
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    chk("tick_lat_early", 0, 32'(disp_addr[0]), 32'd0);
    step(1);
    chk("tick_lat_addr", 0, 32'(disp_addr[0]), 32'd1);
    chk("tick_lat_data", 0, 32'(disp_data[0]), 32'hA);
    chk("tick_lat_early", 1, 32'(disp_addr[1]), 32'd0);
    step(1);
    chk("tick_lat_addr", 1, 32'(disp_addr[1]), 32'd1);
    chk("tick_lat_data", 1, 32'(disp_data[1]), 32'hA);
    step(6);

    // Write to the displayed address forces a re-read.
    repeat (4) do_tick();
    for (int k = 0; k < 2; k++) chk("at5_addr", k, 32'(disp_addr[k]), 32'd5);
    wr_req = 1'b1; wr_addr = 5'd5; wr_data = 4'hC;
    step(1);
    wr_req = 1'b0;
    for (int k = 0; k < 2; k++) chk("refresh_old", k, 32'(disp_data[k]), 32'h6);
    step(4);
    for (int k = 0; k < 2; k++) chk("refresh_new", k, 32'(disp_data[k]), 32'hC);
    step(5);

    // Writes held through ISSUE delay the read, which sees the write.
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = WA[i]; wr_data = WD[i];
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("stall_wren", k, 32'(ram_wren[k]), 32'd1);
        chk("stall_addr", k, 32'(ram_addr[k]), 32'(WA[i]));
      end
      step(1);
    end
    wr_req = 1'b0;
    step(8);
    for (int k = 0; k < 2; k++) begin
      chk("stall_addr_final", k, 32'(disp_addr[k]), 32'd6);
      chk("stall_data_final", k, 32'(disp_data[k]), 32'h9);
    end

    // Three ticks during one read: one pending, two increments total.
    tick = 1'b1;
    step(1);
    wr_req = 1'b1; wr_addr = 5'd25; wr_data = 4'h0;
    step(3);
    tick = 1'b0; wr_req = 1'b0;
    step(20);
    for (int k = 0; k < 2; k++) chk("pending_addr", k, 32'(disp_addr[k]), 32'd8);

    // Walk to 31, wrap, and walk back up to 31.
    for (int i = 0; i < 55; i++) begin
      do_tick();
      ea = 5'((8 + i + 1) % 32);
      for (int k = 0; k < 2; k++) begin
        chk("walk_addr", k, 32'(disp_addr[k]), 32'(ea));
        chk("walk_HEX3", k, 32'(hex3[k]), (ea >= 5'd16) ? 32'h79 : 32'h40);
      end
    end

    // Reset during WAIT aborts the read and clears outputs at once.
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    @(posedge CLOCK_50);
    #2;
    Reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rstw_disp_addr", k, 32'(disp_addr[k]), 32'd0);
      chk("rstw_disp_data", k, 32'(disp_data[k]), 32'd0);
      chk("rstw_ram_addr", k, 32'(ram_addr[k]), 32'd0);
      chk("rstw_HEX0", k, 32'(hex0[k]), 32'h40);
      chk("rstw_HEX2", k, 32'(hex2[k]), 32'h40);
      chk("rstw_HEX3", k, 32'(hex3[k]), 32'h40);
    end
    step(2);
    Reset = 1'b0;
    step(6);
    for (int k = 0; k < 2; k++) begin
      chk("rstw_reread_addr", k, 32'(disp_addr[k]), 32'd0);
      chk("rstw_reread_data", k, 32'(disp_data[k]), 32'h7);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        tick = 1'b0; wr_req = 1'b0;
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
      end else begin
        tick    = ($urandom_range(0, 7) == 0);
        wr_req  = ($urandom_range(0, 3) == 0);
        wr_addr = ($urandom_range(0, 2) == 0) ? m_da[0] : 5'($urandom_range(0, 31));
        wr_data = 4'($urandom_range(0, 15));
      end
      step(1);
    end
    tick = 1'b0; wr_req = 1'b0;
    step(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
